// File: rtl/alu_op_scheduler_pkg.sv
// Shared definitions for the ALU op scheduler: FSM encoding and select-code geometry.
package alu_op_scheduler_pkg;

   localparam int SEL_W   = 2;
   localparam int NUM_OPS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_op_scheduler_mask_lsb_encoder.sv
// Lowest-set-bit encoder: maps an op mask to the sel code of its first requested op.
module mask_lsb_encoder
   import alu_op_scheduler_pkg::*;
(
   input  logic [NUM_OPS-1:0] mask,
   output logic [SEL_W-1:0]   idx,
   output logic               any_set
);

   // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
   always_comb begin
      idx     = '0;
      any_set = 1'b0;
      for (int i = NUM_OPS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx     = SEL_W'(i);
            any_set = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_op_scheduler.sv
// Steps the ALU selector through each requested sel code, captures the settled
// output per code, and hands the result set over on a valid/ready completion.
module alu_op_scheduler
   import alu_op_scheduler_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_mask,
   output logic [1:0]       sel,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] res0,
   output logic [WIDTH-1:0] res1,
   output logic [WIDTH-1:0] res2,
   output logic [WIDTH-1:0] res3,
   output logic [3:0]       res_mask,
   output logic             done_valid,
   input  logic             done_ready
);

   localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

   state_t                 state;
   logic [3:0]             cnt;
   logic [NUM_OPS-1:0]     pending;
   logic [WIDTH-1:0]       res [NUM_OPS];

   logic [NUM_OPS-1:0]     pending_clr;
   logic [SEL_W-1:0]       first_idx;
   logic [SEL_W-1:0]       next_idx;
   logic                   first_any;
   logic                   next_any;

   // Mask left over once the code currently on sel has been captured.
   assign pending_clr = pending & ~(4'b0001 << sel);

   mask_lsb_encoder u_first_enc (
      .mask    (req_mask),
      .idx     (first_idx),
      .any_set (first_any)
   );

   mask_lsb_encoder u_next_enc (
      .mask    (pending_clr),
      .idx     (next_idx),
      .any_set (next_any)
   );

   // NOTE: state and outputs use non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sel        <= '0;
         cnt        <= '0;
         pending    <= '0;
         res_mask   <= '0;
         req_ready  <= 1'b0;
         done_valid <= 1'b0;
         // NOTE: the result array is a small register file, so it is reset like any other state.
         for (int i = 0; i < NUM_OPS; i++) res[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  res_mask  <= req_mask;
                  pending   <= req_mask;
                  for (int i = 0; i < NUM_OPS; i++) res[i] <= '0;
                  if (first_any) begin
                     sel   <= first_idx;
                     cnt   <= CNT_RELOAD;
                     state <= WAIT;
                  end else begin
                     state <= DONE;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  res[sel] <= y;
                  pending  <= pending_clr;
                  if (next_any) begin
                     sel <= next_idx;
                     cnt <= CNT_RELOAD;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               // done_valid rises one cycle after entering DONE.
               if (done_valid && done_ready) begin
                  done_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end else begin
                  done_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign res0 = res[0];
   assign res1 = res[1];
   assign res2 = res[2];
   assign res3 = res[3];

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed scoreboard bench: three schedulers with SETTLE=1,2,3 share clk/rst.
module tb_alu_op_scheduler;

   typedef struct packed {
      logic [3:0]  mask;
      logic [31:0] res;
      logic [7:0]  lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid  [3];
   logic       req_ready  [3];
   logic       done_valid [3];
   logic       done_ready [3];
   logic [3:0] req_mask   [3];
   logic [3:0] res_mask   [3];
   logic [1:0] sel        [3];
   logic [7:0] res0 [3];
   logic [7:0] res1 [3];
   logic [7:0] res2 [3];
   logic [7:0] res3 [3];

   exp_t        sb [$];
   int          n_err    = 0;
   int          n_checks = 0;
   int unsigned cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [7:0] y_g;
      if (g == 0) begin : g_comb
         assign y_g = 8'h10 + {6'b0, sel[g]};
      end else begin : g_dly
         // Selector with one cycle of output delay after sel changes.
         always @(posedge clk) y_g <= 8'(16 * (g + 1)) + {6'b0, sel[g]};
      end
      alu_op_scheduler #(.WIDTH(8), .SETTLE(g + 1)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_mask   (req_mask[g]),
         .sel        (sel[g]),
         .y          (y_g),
         .res0       (res0[g]),
         .res1       (res1[g]),
         .res2       (res2[g]),
         .res3       (res3[g]),
         .res_mask   (res_mask[g]),
         .done_valid (done_valid[g]),
         .done_ready (done_ready[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] res_all(input int d);
      return {res3[d], res2[d], res1[d], res0[d]};
   endfunction

   // One transaction on DUT d; optionally holds DONE for `hold` cycles with a competing request.
   task automatic run_txn(input int d, input logic [3:0] mask, input int hold, input string tag);
      exp_t e;
      int   s = d + 1;
      int   n = 0;
      int   guard = 0;
      int unsigned t0;
      e.mask = mask;
      e.res  = '0;
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) begin
            e.res[k*8 +: 8] = 8'(16 * (d + 1) + k);
            n++;
         end
      end
      e.lat = 8'(1 + n * s);
      sb.push_back(e);

      @(negedge clk);
      check({tag, " req_ready"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_mask[d]  = mask;
      @(negedge clk);
      req_valid[d] = 1'b0;
      t0 = cyc;
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) begin
            for (int r = 0; r < s; r++) begin
               check($sformatf("%s sel k%0d r%0d", tag, k, r), 32'(sel[d]), 32'(k));
               @(negedge clk);
            end
         end
      end
      check({tag, " early_done"}, 32'(done_valid[d]), 32'd0);
      while (!done_valid[d] && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " latency"}, 32'(cyc - t0), 32'(e.lat));
      if (sb.size() == 0) begin
         check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, " res"}, res_all(d), e.res);
         check({tag, " res_mask"}, 32'(res_mask[d]), 32'(e.mask));
      end

      if (hold > 0) begin
         req_valid[d] = 1'b1;
         req_mask[d]  = 4'hF;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold done_valid"}, 32'(done_valid[d]), 32'd1);
            check({tag, " hold req_ready"}, 32'(req_ready[d]), 32'd0);
            check({tag, " hold res"}, res_all(d), e.res);
            check({tag, " hold res_mask"}, 32'(res_mask[d]), 32'(e.mask));
         end
         req_valid[d] = 1'b0;
      end

      done_ready[d] = 1'b1;
      @(negedge clk);
      done_ready[d] = 1'b0;
      check({tag, " post_hs done_valid"}, 32'(done_valid[d]), 32'd0);
      check({tag, " post_hs req_ready"}, 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         req_valid[d]  = 1'b0;
         req_mask[d]   = 4'h0;
         done_ready[d] = 1'b0;
      end

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst res d%0d", d), res_all(d), 32'd0);
         check($sformatf("rst sel d%0d", d), 32'(sel[d]), 32'd0);
         check($sformatf("rst done_valid d%0d", d), 32'(done_valid[d]), 32'd0);
         check($sformatf("rst res_mask d%0d", d), 32'(res_mask[d]), 32'd0);
         check($sformatf("rst req_ready d%0d", d), 32'(req_ready[d]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++)
         check($sformatf("post_rst req_ready d%0d", d), 32'(req_ready[d]), 32'd1);

      // Full mask, SETTLE=1
      run_txn(0, 4'b1111, 0, "T1");
      // Sparse mask, SETTLE=3
      run_txn(2, 4'b1010, 0, "T2");
      // Empty mask: immediate done, sel untouched
      run_txn(2, 4'b0000, 0, "T3");
      check("T3 sel_held", 32'(sel[2]), 32'd3);
      // Stalled consumer with a competing request, then a follow-on request
      run_txn(2, 4'b0101, 10, "T4a");
      run_txn(2, 4'b0011, 0, "T4b");

      // Reset mid-WAIT after two captures
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_mask[0]  = 4'b1111;
      @(negedge clk);
      req_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      check("T5 partial res", res_all(0), 32'h0000_1110);
      rst = 1'b1;
      #1;
      check("T5 async res", res_all(0), 32'd0);
      check("T5 async sel", 32'(sel[0]), 32'd0);
      check("T5 async res_mask", 32'(res_mask[0]), 32'd0);
      check("T5 async done_valid", 32'(done_valid[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("T5 no_done c%0d", i), 32'(done_valid[0]), 32'd0);
      end
      run_txn(0, 4'b0001, 0, "T5b");

      // Delayed selector output, SETTLE=2: capture must see the post-delay value
      run_txn(1, 4'b0110, 0, "T6a");
      run_txn(1, 4'b1001, 0, "T6b");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
